// File: rtl/key_ctrl_pkg.sv
// Shared types and constants for the debounced key-driven BCD counter.
// Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
package key_ctrl_pkg;

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  localparam int NUM_KEYS  = 3;
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_CLEAR = 2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_next(
    input logic [3:0] v,
    input logic       dn
  );
    if (dn)
      return (v == 4'd0 || v > BCD_MAX) ? BCD_MAX : v - 4'd1;
    else
      return (v >= BCD_MAX) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/key_counter_ctrl_debounce.sv
// One key: 2-flop synchronizer, tick-based debounce count, stable value
// and a one-cycle press event on each qualified 0->1 flip.
module key_debounce #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (tick) begin
      if (sync_q != stable_q) begin
        if (cnt_q == CW'(STABLE_TICKS - 1)) begin
          stable_d = ~stable_q;
          press_d  = ~stable_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= key_raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/key_counter_ctrl.sv
// Debounced up/down/clear keys driving a BCD counter with a press lock.
// Define AUTO_REPEAT_EN to repeat up/down while the entry key is held.
module key_counter_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int TICK_BITS    = 16,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_TICKS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [3:0]          led,
  output logic                step,
  output logic                busy
);

  if (TICK_BITS < 1 || STABLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("key_counter_ctrl: parameters must be >= 1");
  end

  logic [TICK_BITS-1:0] presc_q, presc_d;
  logic                 tick;
  logic [NUM_KEYS-1:0]  stable;
  logic [NUM_KEYS-1:0]  press;
  state_e               state_q, state_d;
  logic [3:0]           led_q, led_d;
  logic                 step_q, step_d;
  logic                 busy_q, busy_d;

  assign tick    = &presc_q;
  assign presc_d = presc_q + TICK_BITS'(1);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .key_raw(key[i]),
      .stable (stable[i]),
      .press  (press[i])
    );
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic [RW-1:0]       rpt_q, rpt_d;
  logic [1:0]          rkey_q, rkey_d;
  logic [NUM_KEYS-1:0] stable_prev_q;
  logic                tick_q;
  logic                rpt_hold;

  // Counted one cycle after the tick so a releasing key is already seen low.
  assign rpt_hold = (rkey_q != 2'(KEY_CLEAR)) &&
                    (stable == (NUM_KEYS'(1) << rkey_q));
`endif

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    step_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_d   = rpt_q;
    rkey_d  = rkey_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|press) begin
          state_d = LOCK;
          step_d  = 1'b1;
          if (press[KEY_CLEAR])
            led_d = 4'd0;
          else
            led_d = bcd_next(led_q, !press[KEY_UP]);
`ifdef AUTO_REPEAT_EN
          rpt_d  = '0;
          rkey_d = press[KEY_CLEAR] ? 2'(KEY_CLEAR) :
                   press[KEY_UP]    ? 2'(KEY_UP)    : 2'(KEY_DOWN);
`endif
        end
      end
      LOCK: begin
        if (stable == '0)
          state_d = IDLE;
`ifdef AUTO_REPEAT_EN
        if (stable != stable_prev_q) begin
          rpt_d = '0;
        end else if (tick_q && rpt_hold) begin
          if (rpt_q == RW'(REPEAT_TICKS - 1)) begin
            rpt_d  = '0;
            step_d = 1'b1;
            led_d  = bcd_next(led_q, rkey_q == 2'(KEY_DOWN));
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      state_q       <= IDLE;
      led_q         <= 4'd0;
      step_q        <= 1'b0;
      busy_q        <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_q         <= '0;
      rkey_q        <= 2'(KEY_UP);
      stable_prev_q <= '0;
      tick_q        <= 1'b0;
`endif
    end else begin
      presc_q       <= presc_d;
      state_q       <= state_d;
      led_q         <= led_d;
      step_q        <= step_d;
      busy_q        <= busy_d;
`ifdef AUTO_REPEAT_EN
      rpt_q         <= rpt_d;
      rkey_q        <= rkey_d;
      stable_prev_q <= stable;
      tick_q        <= tick;
`endif
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_key_counter_ctrl.sv
// Directed bench for key_counter_ctrl (TICK_BITS=2, STABLE_TICKS=3,
// REPEAT_TICKS=4); a tick every 4 clocks.
module tb_key_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] key = 3'b000;
  logic [3:0] led;
  logic       step;
  logic       busy;

  int n_run  = 0;
  int n_fail = 0;
  int steps  = 0;
  int cyc    = 0;
  int base   = 0;

  always #5 clk = ~clk;

  key_counter_ctrl #(
    .TICK_BITS   (2),
    .STABLE_TICKS(3),
    .REPEAT_TICKS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .key (key),
    .led (led),
    .step(step),
    .busy(busy)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (step === 1'b1)
      steps <= steps + 1;
  end

`ifdef AUTO_REPEAT_EN
  int         step_cyc[$];
  logic [3:0] step_led[$];

  always @(posedge clk)
    if (step === 1'b1) begin
      step_cyc.push_back(cyc);
      step_led.push_back(led);
    end
`endif

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 12 clocks high covers exactly three ticks of the synchronized key.
  task automatic press(input logic [2:0] k);
    @(negedge clk);
    key = k;
    wait_cyc(12);
    key = 3'b000;
    wait_cyc(32);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wait_cyc(2);
    check("rst_led", 32'(led), 0);
    check("rst_step", 32'(step), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    wait_cyc(4);

`ifndef AUTO_REPEAT_EN
    // Long hold of up: one step only, busy until release qualifies.
    base = steps;
    key  = 3'b001;
    wait_cyc(40);
    check("hold_busy", 32'(busy), 1);
    check("hold_led", 32'(led), 1);
    wait_cyc(40);
    key = 3'b000;
    wait_cyc(4);
    check("rel_busy_early", 32'(busy), 1);
    wait_cyc(28);
    check("rel_busy_late", 32'(busy), 0);
    check("hold_steps", 32'(steps - base), 1);
    check("hold_led_end", 32'(led), 1);
`endif

    // Up wrap sequence 1..9,0 then down wrap 0->9.
    pulse_rst();
    check("seq_rst_led", 32'(led), 0);
    base = steps;
    for (int i = 1; i <= 10; i++) begin
      press(3'b001);
      check("up_seq", 32'(led), 32'(i % 10));
    end
    check("up_seq_steps", 32'(steps - base), 10);
    press(3'b010);
    check("down_wrap", 32'(led), 9);

    // Short pulse followed by per-tick bounce never qualifies.
    base = steps;
    @(negedge clk);
    key = 3'b001;
    wait_cyc(8);
    for (int t = 0; t < 10; t++) begin
      key = {2'b00, ~key[0]};
      wait_cyc(4);
    end
    key = 3'b000;
    wait_cyc(32);
    check("bounce_steps", 32'(steps - base), 0);
    check("bounce_led", 32'(led), 9);
    check("bounce_busy", 32'(busy), 0);

    // All three keys together from 5: clear wins; down in LOCK ignored.
    pulse_rst();
    for (int i = 0; i < 5; i++)
      press(3'b001);
    check("prio_seed", 32'(led), 5);
    base = steps;
    @(negedge clk);
    key = 3'b111;
    wait_cyc(20);
    check("prio_led", 32'(led), 0);
    check("prio_steps", 32'(steps - base), 1);
    key = 3'b001;
    wait_cyc(32);
    key = 3'b011;
    wait_cyc(32);
    check("lock_led", 32'(led), 0);
    check("lock_steps", 32'(steps - base), 1);
    check("lock_busy", 32'(busy), 1);
    key = 3'b000;
    wait_cyc(32);
    check("unlock_busy", 32'(busy), 0);

    // Reset mid-qualification: held key needs full requalification.
    press(3'b001);
    check("prerst_led", 32'(led), 1);
    base = steps;
    @(negedge clk);
    key = 3'b001;
    wait_cyc(9);
    rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 0);
    check("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(12);
    check("requal_led_early", 32'(led), 0);
    check("requal_step_early", 32'(step), 0);
    wait_cyc(1);
    check("requal_led", 32'(led), 1);
    check("requal_step", 32'(step), 1);
    key = 3'b000;
    wait_cyc(32);
    check("requal_steps", 32'(steps - base), 1);
    check("requal_busy", 32'(busy), 0);

`ifdef AUTO_REPEAT_EN
    begin
      logic [3:0] exp_seq [5];
      exp_seq = '{4'd9, 4'd0, 4'd1, 4'd2, 4'd3};
      pulse_rst();
      for (int i = 0; i < 8; i++)
        press(3'b001);
      check("rpt_seed", 32'(led), 8);
      step_cyc.delete();
      step_led.delete();
      base = steps;
      @(negedge clk);
      key = 3'b001;
      wait_cyc(80);
      key = 3'b000;
      wait_cyc(32);
      check("rpt_steps", 32'(steps - base), 5);
      check("rpt_log_len", 32'(step_led.size()), 5);
      for (int i = 0; i < 5 && i < step_led.size(); i++)
        check("rpt_led", 32'(step_led[i]), 32'(exp_seq[i]));
      for (int i = 1; i < 5 && i < step_cyc.size(); i++)
        check("rpt_gap", 32'(step_cyc[i] - step_cyc[i-1]), 16);
      check("rpt_busy", 32'(busy), 0);
      base = steps;
      @(negedge clk);
      key = 3'b100;
      wait_cyc(80);
      key = 3'b000;
      wait_cyc(32);
      check("clr_hold_steps", 32'(steps - base), 1);
      check("clr_hold_led", 32'(led), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
